// File: rtl/piso_bit_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : piso_bit_serializer                                          |
// | Description : Parallel-in/serial-out stage feeding a bit-serial detector.  |
// |               Accepts WIDTH-bit words on a valid/ready handshake and emits |
// |               them one bit per clock, gapless across back-to-back words,   |
// |               with a last-bit flag and a wrapping count of words sent.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module piso_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             bit_valid,
  output logic             last_bit,
  output logic [7:0]       words_sent
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic             x_nxt, bit_valid_nxt, last_bit_nxt;
  logic [7:0]       words_sent_nxt;

  // The register x holds the bit currently on the wire; sreg holds the bits
  // still to come, already shifted so the next one sits at the head.
  logic             load_head, sreg_head;
  logic [WIDTH-1:0] load_rest, sreg_rest;

  logic at_last;
  logic accept;

  assign at_last    = (state == SHIFT) && (cnt == CNT_LAST);
  assign load_ready = !rst && ((state == IDLE) || at_last);
  assign accept     = load_valid && load_ready;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign load_head = data_in[WIDTH-1];
      assign load_rest = {data_in[WIDTH-2:0], 1'b0};
      assign sreg_head = sreg[WIDTH-1];
      assign sreg_rest = {sreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign load_head = data_in[0];
      assign load_rest = {1'b0, data_in[WIDTH-1:1]};
      assign sreg_head = sreg[0];
      assign sreg_rest = {1'b0, sreg[WIDTH-1:1]};
    end
  endgenerate

  // Next-state and next-output logic; idle values are the defaults.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    sreg_nxt       = sreg;
    x_nxt          = IDLE_BIT;
    bit_valid_nxt  = 1'b0;
    words_sent_nxt = words_sent;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt     = SHIFT;
          cnt_nxt       = '0;
          sreg_nxt      = load_rest;
          x_nxt         = load_head;
          bit_valid_nxt = 1'b1;
        end
      end
      SHIFT: begin
        if (!at_last) begin
          cnt_nxt       = cnt + CNT_W'(1);
          sreg_nxt      = sreg_rest;
          x_nxt         = sreg_head;
          bit_valid_nxt = 1'b1;
        end else begin
          // Word completes at this edge whether or not another follows.
          words_sent_nxt = words_sent + 8'd1;
          cnt_nxt        = '0;
          if (accept) begin
            sreg_nxt      = load_rest;
            x_nxt         = load_head;
            bit_valid_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    last_bit_nxt = bit_valid_nxt && (cnt_nxt == CNT_LAST);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      x          <= IDLE_BIT;
      bit_valid  <= 1'b0;
      last_bit   <= 1'b0;
      words_sent <= 8'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sreg       <= sreg_nxt;
      x          <= x_nxt;
      bit_valid  <= bit_valid_nxt;
      last_bit   <= last_bit_nxt;
      words_sent <= words_sent_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_bit_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_piso_bit_serializer                                       |
// | Description : Directed self-checking bench for piso_bit_serializer, with   |
// |               an MSB-first and an LSB-first instance on shared inputs.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_piso_bit_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       load_valid;

  logic       m_ready, m_x, m_bv, m_last;
  logic [7:0] m_words;
  logic       l_ready, l_x, l_bv, l_last;
  logic [7:0] l_words;

  int total = 0;
  int bad   = 0;

  logic [7:0]  w;
  logic [15:0] w16;

  always #5 clk = ~clk;

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(m_ready), .x(m_x), .bit_valid(m_bv), .last_bit(m_last),
    .words_sent(m_words)
  );

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(l_ready), .x(l_x), .bit_valid(l_bv), .last_bit(l_last),
    .words_sent(l_words)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    load_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset with load_valid held high
    rst        = 1'b1;
    load_valid = 1'b1;
    data_in    = 8'hA5;
    #1;
    chk("rst_ready_pre", {31'd0, m_ready}, 32'd0);
    step();
    step();
    chk("rst_ready",  {31'd0, m_ready}, 32'd0);
    chk("rst_bv",     {31'd0, m_bv},    32'd0);
    chk("rst_x",      {31'd0, m_x},     32'd0);
    chk("rst_last",   {31'd0, m_last},  32'd0);
    chk("rst_words",  {24'd0, m_words}, 32'd0);
    rst        = 1'b0;
    load_valid = 1'b0;
    step();
    chk("post_rst_bv",    {31'd0, m_bv},    32'd0);
    chk("post_rst_ready", {31'd0, m_ready}, 32'd1);

    // 2: single word A5, MSB first
    w          = 8'hA5;
    data_in    = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    data_in    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_x%0d", i),    {31'd0, m_x},    {31'd0, w[7-i]});
      chk($sformatf("t2_bv%0d", i),   {31'd0, m_bv},   32'd1);
      chk($sformatf("t2_last%0d", i), {31'd0, m_last}, (i == 7) ? 32'd1 : 32'd0);
      if (i == 3) chk("t2_ready_mid", {31'd0, m_ready}, 32'd0);
      if (i == 7) chk("t2_ready_end", {31'd0, m_ready}, 32'd1);
      step();
    end
    chk("t2_bv_after",  {31'd0, m_bv},    32'd0);
    chk("t2_x_after",   {31'd0, m_x},     32'd0);
    chk("t2_words",     {24'd0, m_words}, 32'd1);

    // 3: back-to-back A5 then 3C with load_valid held
    do_reset();
    w16        = 16'b10100101_00111100;
    data_in    = 8'hA5;
    load_valid = 1'b1;
    step();
    data_in = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) load_valid = 1'b0;
      chk($sformatf("t3_x%0d", i),    {31'd0, m_x},    {31'd0, w16[15-i]});
      chk($sformatf("t3_bv%0d", i),   {31'd0, m_bv},   32'd1);
      chk($sformatf("t3_last%0d", i), {31'd0, m_last}, (i == 7 || i == 15) ? 32'd1 : 32'd0);
      step();
    end
    chk("t3_bv_after", {31'd0, m_bv},    32'd0);
    chk("t3_words",    {24'd0, m_words}, 32'd2);

    // 4: LSB-first instance with 01; MSB-first instance sees the mirror
    do_reset();
    data_in    = 8'h01;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_lx%0d", i), {31'd0, l_x}, (i == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t4_mx%0d", i), {31'd0, m_x}, (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("t4_llast%0d", i), {31'd0, l_last}, (i == 7) ? 32'd1 : 32'd0);
      step();
    end
    chk("t4_lwords", {24'd0, l_words}, 32'd1);

    // 5: reset after three bits of FF, then a fresh word 96
    do_reset();
    data_in    = 8'hFF;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_x%0d", i), {31'd0, m_x}, 32'd1);
      step();
    end
    rst = 1'b1;
    load_valid = 1'b1;
    #1;
    chk("t5_ready_in_rst", {31'd0, m_ready}, 32'd0);
    step();
    rst        = 1'b0;
    load_valid = 1'b0;
    chk("t5_bv",    {31'd0, m_bv},    32'd0);
    chk("t5_x",     {31'd0, m_x},     32'd0);
    chk("t5_last",  {31'd0, m_last},  32'd0);
    chk("t5_words", {24'd0, m_words}, 32'd0);
    w          = 8'h96;
    data_in    = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_nx%0d", i), {31'd0, m_x}, {31'd0, w[7-i]});
      step();
    end
    chk("t5_nwords", {24'd0, m_words}, 32'd1);

    // 6: 256 back-to-back words, counter wraps to zero
    do_reset();
    data_in    = 8'h55;
    load_valid = 1'b1;
    step();
    for (int k = 0; k < 255 * 8; k++) begin
      chk("t6_gapless", {31'd0, m_bv}, 32'd1);
      step();
    end
    chk("t6_words255", {24'd0, m_words}, 32'd255);
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t6_x%0d", i), {31'd0, m_x}, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
    end
    chk("t6_words_wrap", {24'd0, m_words}, 32'd0);
    chk("t6_bv_after",   {31'd0, m_bv},    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
